// File: rtl/sc_tx_arbiter.sv
// N-channel slow-control TX arbiter: fixed-priority or round-robin grant of per-source queues onto the sctx_* port.
// Latency: grant (ch_txack) registered one cycle after sctx_ack && request; sctx_* fields are combinational muxes of the owner.
// Backpressure: arbitration waits for sctx_ack; the owner holds the port until its txdone (or timeout with SCTX_ARB_TIMEOUT_EN).
module sc_tx_arbiter #(
    parameter int NCH     = 4,
    parameter int TIMEOUT = 65535,
    parameter int TO_W    = 16
) (
    input  logic              clk125,
    input  logic              rstn,
    input  logic              cfg_rr,
    input  logic [15:0]       cfg_scport,
    input  logic [NCH-1:0]    cfg_dstovr,
    input  logic [NCH-1:0]    ch_txreq,
    input  logic [NCH-1:0]    ch_txstart,
    input  logic [NCH-1:0]    ch_txdone,
    input  logic [8*NCH-1:0]  ch_txdata,
    input  logic [16*NCH-1:0] ch_srcport,
    input  logic [16*NCH-1:0] ch_dstport,
    input  logic [32*NCH-1:0] ch_dstip,
    input  logic [16*NCH-1:0] ch_length,
    output logic [NCH-1:0]    ch_txack,
    output logic              sctx_req,
    input  logic              sctx_ack,
    output logic [15:0]       sctx_udptxSrcPort,
    output logic [15:0]       sctx_udptxDstPort,
    output logic [15:0]       sctx_udptxlength,
    output logic [31:0]       sctx_udptxDstIP,
    output logic [7:0]        sctx_data,
    output logic              sctx_start,
    output logic              sctx_stop,
    output logic              sctx_done,
    output logic              to_err,
    output logic [2:0]        to_ch
);
    // Optional feature macro: SCTX_ARB_TIMEOUT_EN (abort a grant held for TIMEOUT cycles).

    // Reject parameter combinations the index/counter widths cannot hold.
    if (NCH < 2 || NCH > 8 || TIMEOUT < 1 || TIMEOUT >= (2 ** TO_W)) begin : g_bad_params
        $error("sc_tx_arbiter: NCH must be 2..8 and 1 <= TIMEOUT < 2**TO_W");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1
    } state_t;

    state_t         state;
    logic [2:0]     g;
    logic [2:0]     ptr;
    logic [2:0]     sel;
    logic           sel_vld;
    logic [2:0]     base;
    logic [2:0]     ptr_nxt;
    logic [NCH-1:0] sel_onehot;
    logic           busy;
    logic           done_g;
    int             idx;

    assign busy     = (state == BUSY);
    assign sctx_req = |ch_txreq;
    assign sctx_stop = 1'b1;
    // ch_txack is the one-hot of g, so masking with it picks the owner's bit without a variable index.
    assign done_g     = |(ch_txdone & ch_txack);
    assign sel_onehot = NCH'(1) << sel;
    assign ptr_nxt    = (int'(sel) == NCH - 1) ? 3'd0 : sel + 3'd1;

    // Pick the first requesting channel at or after base (0 in fixed mode, ptr in round-robin).
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        idx     = 0;
        base    = cfg_rr ? ptr : 3'd0;
        for (int k = 0; k < NCH; k++) begin
            idx = int'(base) + k;
            if (idx >= NCH) idx = idx - NCH;
            if (!sel_vld && (((ch_txreq >> idx) & NCH'(1)) != '0)) begin
                sel_vld = 1'b1;
                sel     = 3'(idx);
            end
        end
    end

`ifdef SCTX_ARB_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    logic [TO_W-1:0] to_cnt;

    // Arbitration FSM with grant register, round-robin pointer and hold-time watchdog.
    always_ff @(posedge clk125 or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            g        <= '0;
            ch_txack <= '0;
            ptr      <= '0;
            to_cnt   <= '0;
            to_err   <= 1'b0;
            to_ch    <= '0;
        end else begin
            to_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (sctx_ack && sel_vld) begin
                        state    <= BUSY;
                        g        <= sel;
                        ch_txack <= sel_onehot;
                        to_cnt   <= '0;
                        if (cfg_rr) ptr <= ptr_nxt;
                    end
                end
                BUSY: begin
                    if (done_g) begin
                        state    <= IDLE;
                        ch_txack <= '0;
                    end else if (to_cnt == TO_LAST) begin
                        state    <= IDLE;
                        ch_txack <= '0;
                        to_err   <= 1'b1;
                        to_ch    <= g;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    ch_txack <= '0;
                end
            endcase
        end
    end
`else
    assign to_err = 1'b0;
    assign to_ch  = 3'd0;

    // Arbitration FSM with grant register and round-robin pointer; a grant ends only on txdone.
    always_ff @(posedge clk125 or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            g        <= '0;
            ch_txack <= '0;
            ptr      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sctx_ack && sel_vld) begin
                        state    <= BUSY;
                        g        <= sel;
                        ch_txack <= sel_onehot;
                        if (cfg_rr) ptr <= ptr_nxt;
                    end
                end
                BUSY: begin
                    if (done_g) begin
                        state    <= IDLE;
                        ch_txack <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    ch_txack <= '0;
                end
            endcase
        end
    end
`endif

    // Route the owner's fields to the TX port while BUSY; idle values otherwise.
    always_comb begin
        sctx_udptxSrcPort = '0;
        sctx_udptxDstPort = '0;
        sctx_udptxlength  = '0;
        sctx_udptxDstIP   = '0;
        sctx_data         = '0;
        sctx_start        = 1'b0;
        sctx_done         = 1'b1;
        if (busy) begin
            sctx_udptxSrcPort = 16'(ch_srcport >> (16 * int'(g)));
            sctx_udptxDstPort = (|(cfg_dstovr & ch_txack)) ? cfg_scport
                                                          : 16'(ch_dstport >> (16 * int'(g)));
            sctx_udptxlength  = 16'(ch_length >> (16 * int'(g)));
            sctx_udptxDstIP   = 32'(ch_dstip >> (32 * int'(g)));
            sctx_data         = 8'(ch_txdata >> (8 * int'(g)));
            sctx_start        = |(ch_txstart & ch_txack);
            sctx_done         = done_g;
        end
    end

endmodule
